q2_mem: RTL and testbench

Q2_MEM -- requirements
Module: q2_mem

---
 rtl/q2_mem.sv | 221 ++++++++++++++++++++++
 tb/tb_q2_mem.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/q2_mem.sv
// q2_mem: single-port word memory shared by a CPU bus port and a front panel.
// The bus side is a four-state handshake FSM with a programmable wait count.
// The panel side works only while the CPU is halted: load address, deposit
// and step. pdata continuously shows the word at the panel address.
module q2_mem #(
  parameter int DW   = 12,
  parameter int AW   = 12,
  parameter int WAIT = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] abus,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  input  logic          rdm,
  input  logic          wrm,
  output logic          rdy,
  output logic          err,
  input  logic          run,
  input  logic [DW-1:0] sw,
  input  logic          load_sw,
  input  logic          dep_sw,
  input  logic          incp_sw,
  output logic [AW-1:0] pa,
  output logic [DW-1:0] pdata
);

  localparam int DEPTH = 1 << AW;
  // The counter starts at WAIT-1 so DONE is reached WAIT+1 cycles after the request.
  localparam logic [3:0] CNT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  // Storage (no reset: contents survive rst)
  logic [DW-1:0] mem [0:DEPTH-1];

  // Bus FSM state and captured request
  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          wr_q, wr_d;
  logic          err_q, err_d;

  // Panel state
  logic [AW-1:0] pa_q, pa_d;
  logic [2:0]    sw_prev_q, sw_prev_d;
  logic [2:0]    sw_lvl;
  logic [2:0]    sw_edge;
  logic [AW-1:0] sw_addr;
  logic          panel_ok;
  logic          load_act, dep_act, incp_act;

  // Read outputs
  logic [DW-1:0] dout_q;
  logic [DW-1:0] pdata_q;
  logic          rd_en;
  logic [AW-1:0] rd_addr;

  // Write port
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

  // Switch bit order: 0 = load, 1 = deposit, 2 = increment
  assign sw_lvl = {incp_sw, dep_sw, load_sw};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sw_edge
      assign sw_edge[gi] = sw_lvl[gi] & ~sw_prev_q[gi];
    end
  endgenerate

  // Panel address taken from the switch word, truncated or zero-extended
  generate
    if (AW <= DW) begin : g_addr_trunc
      assign sw_addr = sw[AW-1:0];
    end else begin : g_addr_zext
      assign sw_addr = {{(AW - DW){1'b0}}, sw};
    end
  endgenerate

  // Panel only acts while halted and the bus is idle; load beats deposit beats increment
  assign panel_ok = ~run && (state_q == S_IDLE);
  assign load_act = panel_ok & sw_edge[0];
  assign dep_act  = panel_ok & sw_edge[1] & ~sw_edge[0];
  assign incp_act = panel_ok & sw_edge[2] & ~sw_edge[1] & ~sw_edge[0];

  // Register update for FSM, captured request, panel address and edge detectors
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      data_q    <= '0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      pa_q      <= '0;
      sw_prev_q <= sw_lvl;  // switches held through reset must not fire
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wr_q      <= wr_d;
      err_q     <= err_d;
      pa_q      <= pa_d;
      sw_prev_q <= sw_prev_d;
    end
  end

  // Next-state logic for the bus FSM and the panel address
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    wr_d      = wr_q;
    err_d     = 1'b0;
    pa_d      = pa_q;
    sw_prev_d = sw_lvl;

    case (state_q)
      S_IDLE: begin
        if (run) begin
          if (rdm && wrm) begin
            err_d   = 1'b1;
            state_d = S_HOLD;
          end else if (rdm || wrm) begin
            addr_d = abus;
            wr_d   = wrm;
            if (wrm) begin
              data_d = din;
            end
            cnt_d   = CNT_INIT;
            state_d = (WAIT == 0) ? S_DONE : S_WAIT;
          end
        end else begin
          if (load_act) begin
            pa_d = sw_addr;
          end else if (dep_act || incp_act) begin
            pa_d = pa_q + 1'b1;  // wraps naturally at 2**AW
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (!rdm && !wrm) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from the FSM state
  always_comb begin
    rdy = (state_q == S_DONE);
    err = err_q;
  end

  // Read is launched on the edge entering DONE so dout is valid while rdy=1
  always_comb begin
    rd_en   = ~rst && (state_d == S_DONE) && ~wr_d;
    rd_addr = addr_d;
  end

  // Single write port: bus write in DONE or panel deposit in IDLE never coincide
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr_q;
    mem_wdata = data_q;
    if (!rst) begin
      if (dep_act) begin
        mem_we    = 1'b1;
        mem_waddr = pa_q;
        mem_wdata = sw;
      end else if (state_q == S_DONE && wr_q) begin
        mem_we = 1'b1;
      end
    end
  end

  // Memory write
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Registered reads: bus data held between accesses, panel word refreshed every cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= '0;
    end else if (rd_en) begin
      dout_q <= mem[rd_addr];
    end
    pdata_q <= mem[pa_q];
  end

  assign dout  = dout_q;
  assign pa    = pa_q;
  assign pdata = pdata_q;

endmodule

// File: tb/tb_q2_mem.sv
// tb_q2_mem: scoreboard bench for q2_mem. Instance 0 uses WAIT=2, instance 1
// uses WAIT=0. Expected read data / panel words are queued at stimulus time
// and popped when the DUT completes the transaction.
module tb_q2_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst_v, run_v, rdm_v, wrm_v, load_v, dep_v, incp_v;
  logic [1:0]       rdy_v, err_v;
  logic [1:0][11:0] abus_v, din_v, sw_v;
  logic [1:0][11:0] dout_v, pa_v, pdata_v;

  int n_vec = 0;
  int n_err = 0;

  logic [11:0] mm [int];   // reference memory, key = inst*4096 + addr
  logic [11:0] pa_m [2];   // reference panel address
  logic [31:0] sb [$];     // scoreboard of expected results

  q2_mem #(.DW(12), .AW(12), .WAIT(2)) dut0 (
    .clk(clk), .rst(rst_v[0]), .abus(abus_v[0]), .din(din_v[0]), .dout(dout_v[0]),
    .rdm(rdm_v[0]), .wrm(wrm_v[0]), .rdy(rdy_v[0]), .err(err_v[0]), .run(run_v[0]),
    .sw(sw_v[0]), .load_sw(load_v[0]), .dep_sw(dep_v[0]), .incp_sw(incp_v[0]),
    .pa(pa_v[0]), .pdata(pdata_v[0])
  );

  q2_mem #(.DW(12), .AW(12), .WAIT(0)) dut1 (
    .clk(clk), .rst(rst_v[1]), .abus(abus_v[1]), .din(din_v[1]), .dout(dout_v[1]),
    .rdm(rdm_v[1]), .wrm(wrm_v[1]), .rdy(rdy_v[1]), .err(err_v[1]), .run(run_v[1]),
    .sw(sw_v[1]), .load_sw(load_v[1]), .dep_sw(dep_v[1]), .incp_sw(incp_v[1]),
    .pa(pa_v[1]), .pdata(pdata_v[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bus access; hold = extra cycles the request stays high after rdy
  task automatic bus(input int s, input bit wr, input logic [11:0] a,
                     input logic [11:0] d, input int hold);
    int cyc;
    int extra;
    logic got;
    logic [31:0] exp;
    abus_v[s] = a;
    din_v[s]  = d;
    wrm_v[s]  = wr;
    rdm_v[s]  = ~wr;
    if (wr) mm[s*4096 + int'(a)] = d;
    else    sb.push_back({20'd0, mm[s*4096 + int'(a)]});
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      tick();
      cyc++;
      got = rdy_v[s];
    end
    check($sformatf("latency%0d", s), cyc, (s == 0) ? 3 : 1);
    if (!wr) begin
      exp = sb.pop_front();
      check($sformatf("dout%0d@%03h", s, a), {20'd0, dout_v[s]}, exp);
    end
    extra = 0;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (rdy_v[s]) extra++;
    end
    rdm_v[s] = 1'b0;
    wrm_v[s] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (rdy_v[s]) extra++;
    end
    check($sformatf("dup_rdy%0d", s), extra, 0);
    $display("bus%0d %s addr=%03h data=%03h latency=%0d", s, wr ? "WR" : "RD", a,
             wr ? d : dout_v[s], cyc);
  endtask

  // Panel action on instance 0; switches high for 2+hold cycles, then released
  task automatic panel(input bit ld, input bit dp, input bit ic,
                       input logic [11:0] swv, input int hold);
    bit have_word;
    sw_v[0]   = swv;
    load_v[0] = ld;
    dep_v[0]  = dp;
    incp_v[0] = ic;
    if (!run_v[0]) begin
      if (ld) pa_m[0] = swv;
      else if (dp) begin
        mm[int'(pa_m[0])] = swv;
        pa_m[0] = pa_m[0] + 12'd1;
      end else if (ic) pa_m[0] = pa_m[0] + 12'd1;
    end
    have_word = mm.exists(int'(pa_m[0]));
    sb.push_back({20'd0, pa_m[0]});
    if (have_word) sb.push_back({20'd0, mm[int'(pa_m[0])]});
    tick();
    tick();
    for (int i = 0; i < hold; i++) tick();
    load_v[0] = 1'b0;
    dep_v[0]  = 1'b0;
    incp_v[0] = 1'b0;
    tick();
    check("panel_pa", {20'd0, pa_v[0]}, sb.pop_front());
    if (have_word) check("panel_pdata", {20'd0, pdata_v[0]}, sb.pop_front());
    $display("panel ld=%0b dep=%0b inc=%0b sw=%03h pa=%03h pdata=%03h",
             ld, dp, ic, swv, pa_v[0], pdata_v[0]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ecnt;
    int rcnt;
    logic [11:0] ra [4];
    logic [11:0] rd [4];

    rst_v = 2'b11; run_v = 2'b11; rdm_v = 2'b00; wrm_v = 2'b00;
    load_v = 2'b00; dep_v = 2'b00; incp_v = 2'b00;
    abus_v = '0; din_v = '0; sw_v = '0;
    pa_m[0] = 12'd0; pa_m[1] = 12'd0;

    // Reset with deposit switch held on a halted instance
    run_v[0] = 1'b0;
    dep_v[0] = 1'b1;
    sw_v[0]  = 12'h0AA;
    repeat (3) tick();
    for (int s = 0; s < 2; s++) begin
      check($sformatf("rst_rdy%0d", s), {31'd0, rdy_v[s]}, 0);
      check($sformatf("rst_err%0d", s), {31'd0, err_v[s]}, 0);
      check($sformatf("rst_pa%0d", s), {20'd0, pa_v[s]}, 0);
      check($sformatf("rst_dout%0d", s), {20'd0, dout_v[s]}, 0);
    end
    rst_v = 2'b00;
    tick();
    tick();
    check("held_dep_no_fire", {20'd0, pa_v[0]}, 0);
    dep_v[0] = 1'b0;
    run_v[0] = 1'b1;
    tick();

    // Basic write/read and preload of words used later
    bus(0, 1'b1, 12'h123, 12'h5A5, 0);
    bus(0, 1'b0, 12'h123, 12'h000, 0);
    bus(0, 1'b1, 12'h000, 12'h3C3, 0);
    bus(0, 1'b1, 12'h010, 12'h777, 0);
    bus(0, 1'b1, 12'h040, 12'h111, 0);
    bus(0, 1'b1, 12'h041, 12'h999, 0);
    bus(0, 1'b1, 12'h200, 12'h606, 0);
    bus(0, 1'b1, 12'hFFF, 12'h5EE, 0);
    for (int i = 0; i < 4; i++) begin
      ra[i] = 12'h300 + 12'(i * 17 + $urandom_range(0, 15));
      rd[i] = 12'($urandom_range(0, 4095));
      bus(0, 1'b1, ra[i], rd[i], 0);
    end
    for (int i = 0; i < 4; i++) bus(0, 1'b0, ra[i], 12'h000, 0);

    // Zero-wait instance: back-to-back accesses, requests held past rdy
    bus(1, 1'b1, 12'h055, 12'h0AB, 3);
    bus(1, 1'b0, 12'h055, 12'h000, 3);
    bus(1, 1'b1, 12'h056, 12'h0CD, 0);
    bus(1, 1'b0, 12'h056, 12'h000, 0);
    bus(1, 1'b0, 12'h055, 12'h000, 4);

    // Simultaneous read and write request is a protocol error
    abus_v[0] = 12'h010;
    din_v[0]  = 12'h123;
    rdm_v[0]  = 1'b1;
    wrm_v[0]  = 1'b1;
    ecnt = 0;
    rcnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (err_v[0]) ecnt++;
      if (rdy_v[0]) rcnt++;
    end
    rdm_v[0] = 1'b0;
    wrm_v[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (err_v[0]) ecnt++;
      if (rdy_v[0]) rcnt++;
    end
    check("err_pulses", ecnt, 1);
    check("err_no_rdy", rcnt, 0);
    $display("bus0 RD+WR addr=010 err_pulses=%0d", ecnt);
    bus(0, 1'b0, 12'h010, 12'h000, 0);

    // Request held off while halted
    run_v[0]  = 1'b0;
    abus_v[0] = 12'h123;
    rdm_v[0]  = 1'b1;
    rcnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rdy_v[0]) rcnt++;
    end
    check("halted_no_rdy", rcnt, 0);
    run_v[0] = 1'b1;
    bus(0, 1'b0, 12'h123, 12'h000, 0);

    // Panel: load top address, deposit wraps pa to 0
    run_v[0] = 1'b0;
    panel(1'b1, 1'b0, 1'b0, 12'hFFF, 0);
    panel(1'b0, 1'b1, 1'b0, 12'hABC, 0);
    panel(1'b1, 1'b0, 1'b0, 12'hFFF, 0);

    // Panel edges ignored while running
    run_v[0] = 1'b1;
    panel(1'b0, 1'b0, 1'b1, 12'h000, 0);
    run_v[0] = 1'b0;

    // Priority and held deposit
    panel(1'b1, 1'b0, 1'b1, 12'h040, 0);
    panel(1'b0, 1'b1, 1'b0, 12'h222, 8);
    panel(1'b1, 1'b0, 1'b0, 12'h040, 0);
    panel(1'b0, 1'b0, 1'b1, 12'h000, 0);
    panel(1'b1, 1'b1, 1'b0, 12'h041, 0);
    run_v[0] = 1'b1;
    tick();

    // Reset in the middle of a waited write aborts it
    abus_v[0] = 12'h200;
    din_v[0]  = 12'h0F0;
    wrm_v[0]  = 1'b1;
    tick();
    rst_v[0] = 1'b1;
    tick();
    check("abort_rdy", {31'd0, rdy_v[0]}, 0);
    check("abort_err", {31'd0, err_v[0]}, 0);
    check("abort_pa", {20'd0, pa_v[0]}, 0);
    check("abort_dout", {20'd0, dout_v[0]}, 0);
    $display("rst during WAIT of write addr=200");
    rst_v[0] = 1'b0;
    wrm_v[0] = 1'b0;
    pa_m[0]  = 12'd0;
    tick();
    bus(0, 1'b0, 12'h200, 12'h000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
